// File: rtl/wb_write_queue.sv
// In-order write-back retirement queue feeding the register file write port.
// Buffers completed results, retires one per cycle and forwards pending values to decode.
module wb_write_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                    Clock,
  input  logic                    ResetN,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [ADDR_WIDTH-1:0]   InAddress,
  input  logic [DATA_WIDTH-1:0]   InData,
  input  logic                    PortBusy,
  output logic                    RegWrite,
  output logic [ADDR_WIDTH-1:0]   WriteAddress,
  output logic [DATA_WIDTH-1:0]   WriteData,
  input  logic [ADDR_WIDTH-1:0]   ReadAddress1,
  input  logic [ADDR_WIDTH-1:0]   ReadAddress2,
  output logic                    FwdHit1,
  output logic                    FwdHit2,
  output logic [DATA_WIDTH-1:0]   FwdData1,
  output logic [DATA_WIDTH-1:0]   FwdData2,
  output logic [$clog2(DEPTH):0]  Count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic full, empty, store, retire;
  logic [PtrW-1:0] fwd_idx;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // Writes to the zero register complete the handshake but are dropped.
  assign store  = InValid && !full && (InAddress != '0);
  assign retire = !empty && !PortBusy;

  assign InReady      = !full;
  assign RegWrite     = retire;
  assign WriteAddress = empty ? '0 : addr_q[rd_ptr_q];
  assign WriteData    = empty ? '0 : data_q[rd_ptr_q];
  assign Count        = count_q;

  always_comb begin
    wr_ptr_d = store  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = retire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CntW'(store) - CntW'(retire);
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (store) begin
      addr_q[wr_ptr_q] <= InAddress;
      data_q[wr_ptr_q] <= InData;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    FwdHit1  = 1'b0;
    FwdHit2  = 1'b0;
    FwdData1 = '0;
    FwdData2 = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PtrW'(i);
      if (CntW'(i) < count_q) begin
        if ((ReadAddress1 != '0) && (addr_q[fwd_idx] == ReadAddress1)) begin
          FwdHit1  = 1'b1;
          FwdData1 = data_q[fwd_idx];
        end
        if ((ReadAddress2 != '0) && (addr_q[fwd_idx] == ReadAddress2)) begin
          FwdHit2  = 1'b1;
          FwdData2 = data_q[fwd_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_wb_write_queue;

  localparam int unsigned Depth = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        port_busy;
  logic        reg_write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  ra1, ra2;
  logic        hit1, hit2;
  logic [31:0] fdata1, fdata2;
  logic [2:0]  count;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  int   checks   = 0;
  int   failures = 0;
  bit   last_acc;

  wb_write_queue #(
    .DEPTH     (Depth),
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .Clock       (clk),
    .ResetN      (rst_n),
    .InValid     (in_valid),
    .InReady     (in_ready),
    .InAddress   (in_addr),
    .InData      (in_data),
    .PortBusy    (port_busy),
    .RegWrite    (reg_write),
    .WriteAddress(wr_addr),
    .WriteData   (wr_data),
    .ReadAddress1(ra1),
    .ReadAddress2(ra2),
    .FwdHit1     (hit1),
    .FwdHit2     (hit2),
    .FwdData1    (fdata1),
    .FwdData2    (fdata2),
    .Count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Youngest pending entry for a read address; address 0 never hits.
  task automatic model_fwd(input logic [4:0] ra, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (ra != 0) begin
      for (int j = mq.size() - 1; j >= 0; j--) begin
        if (mq[j].a == ra) begin
          hit = 1'b1;
          d   = mq[j].d;
          break;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic h;
    logic [31:0] d;
    n = mq.size();
    check({tag, ".ready"}, in_ready, 32'(n != Depth));
    check({tag, ".regwrite"}, reg_write, 32'((n > 0) && !port_busy));
    check({tag, ".waddr"}, wr_addr, (n > 0) ? 32'(mq[0].a) : 32'd0);
    check({tag, ".wdata"}, wr_data, (n > 0) ? mq[0].d : 32'd0);
    check({tag, ".count"}, count, 32'(n));
    model_fwd(ra1, h, d);
    check({tag, ".hit1"}, hit1, 32'(h));
    check({tag, ".fdata1"}, fdata1, d);
    model_fwd(ra2, h, d);
    check({tag, ".hit2"}, hit2, 32'(h));
    check({tag, ".fdata2"}, fdata2, d);
  endtask

  // Called at a falling edge: drive, check combinational outputs, clock, update model.
  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic busy, input logic [4:0] r1, input logic [4:0] r2,
                      input string tag);
    bit ret;
    in_valid  = v;
    in_addr   = a;
    in_data   = d;
    port_busy = busy;
    ra1       = r1;
    ra2       = r2;
    #1;
    check_all(tag);
    @(posedge clk);
    ret      = (mq.size() > 0) && !busy;
    last_acc = v && (mq.size() != Depth);
    if (ret) void'(mq.pop_front());
    if (last_acc && (a != 0)) mq.push_back('{a: a, d: d});
    @(negedge clk);
  endtask

  task automatic idle(input logic busy, input string tag);
    step(1'b0, 5'd0, 32'd0, busy, 5'd0, 5'd0, tag);
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    port_busy = 1'b0;
    ra1       = '0;
    ra2       = '0;
    #2;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write: visible on the write port the cycle after acceptance.
    step(1'b1, 5'd1, 32'hAAAABBBB, 1'b0, 5'd0, 5'd0, "single_enq");
    check("single.regwrite_const", reg_write, 32'd1);
    check("single.waddr_const", wr_addr, 32'd1);
    check("single.wdata_const", wr_data, 32'hAAAABBBB);
    idle(1'b0, "single_wr");
    idle(1'b0, "single_done");

    // Fill and stall, then release with r5 held by the producer.
    for (int k = 1; k <= 5; k++)
      step(1'b1, 5'(k), 32'(k) * 32'h11111111, 1'b1, 5'd0, 5'd0, "fill");
    check("fill.ready_const", in_ready, 32'd0);
    check("fill.count_const", count, 32'd4);
    last_acc = 1'b0;
    for (int k = 0; k < 8 && !last_acc; k++)
      step(1'b1, 5'd5, 32'h55555555, 1'b0, 5'd0, 5'd0, "release");
    check("release.accepted", 32'(last_acc), 32'd1);
    repeat (5) idle(1'b0, "drain1");

    // Forwarding: youngest duplicate wins, address 0 never hits.
    step(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 5'd0, "fwd_a");
    step(1'b1, 5'd5, 32'h22222222, 1'b1, 5'd5, 5'd0, "fwd_b");
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, "fwd_hit");
    check("fwd.hit1_const", hit1, 32'd1);
    check("fwd.fdata1_const", fdata1, 32'h22222222);
    repeat (3) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0, "fwd_drain");
    check("fwd.hit1_after", hit1, 32'd0);

    // Zero-register writes are accepted but never stored.
    step(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, "zero_enq");
    idle(1'b0, "zero_after");
    check("zero.count_const", count, 32'd0);

    // Wrap-around with PortBusy toggling every cycle.
    cyc = 0;
    for (int k = 0; k < 10; k++) begin
      last_acc = 1'b0;
      for (int t = 0; t < 8 && !last_acc; t++) begin
        step(1'b1, 5'(10 + k), 32'hC0DE0000 + 32'(k), 1'(cyc % 2), 5'(10 + k), 5'd12, "wrap");
        cyc++;
      end
    end
    repeat (10) begin
      idle(1'(cyc % 2), "wrap_drain");
      cyc++;
    end

    // Reset mid-drain clears everything without a clock edge.
    step(1'b1, 5'd7, 32'h77770000, 1'b1, 5'd7, 5'd8, "prerst_a");
    step(1'b1, 5'd8, 32'h88880000, 1'b1, 5'd7, 5'd8, "prerst_b");
    in_valid  = 1'b0;
    port_busy = 1'b0;
    #2;
    rst_n = 1'b0;
    mq.delete();
    #1;
    check_all("midreset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0, "postreset");

    // Random traffic over a small address range to exercise duplicates and hits.
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), "rand");
    repeat (6) idle(1'b0, "rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
